vga_sync_generator: RTL and testbench
=====================================

// Module: vga_sync_generator
// PURPOSE
//  Downstream stage of the 800-cycle horizontal pixel counter. Consumes its count and line-wrap enable.
//  Owns the vertical line counter (0..524).
//  Decodes both counts into registered hsync/vsync, video_on and pixel_x/pixel_y for the pixel/RGB stage.
//  Fixed 640x480@60 Hz timing on the 25 MHz pixel clock.
// PARAMETERS
//  H_VISIBLE  640  visible pixels per line
//  H_FP       16   horizontal front porch, cycles
//  H_SYNC     96   hsync pulse width, cycles
//  H_BP       48   horizontal back porch, cycles (H_TOTAL = 800)
//  V_VISIBLE  480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BP       33   vertical back porch, lines (V_TOTAL = 525)
//  SYNC_POL   0    active level of hsync/vsync; inactive = ~SYNC_POL
// PORTS
//  clk_25Mhz         in   1   pixel clock, single clock domain
//  rst_n             in   1   asynchronous reset, active-low
//  H_Count_Value     in   16  horizontal position 0..799 from horizontal counter
//  enable_V_Counter  in   1   high for one cycle, coincident with H_Count_Value==0
//  hsync             out  1   horizontal sync, level SYNC_POL while active
//  vsync             out  1   vertical sync, level SYNC_POL while active
//  video_on          out  1   1 inside the 640x480 visible window
//  pixel_x           out  10  column, valid when video_on; else 0
//  pixel_y           out  10  row, valid when video_on; else 0
//  frame_start       out  1   one-cycle pulse at decoded position (0,0)
// BEHAVIOUR
//  Reset (async assert, sync release) drives the following values:
//   v_count=0, hsync=vsync=~SYNC_POL, video_on=0, pixel_x=pixel_y=0, frame_start=0.
//  v_next = enable_V_Counter ? ((v_count==V_TOTAL-1) ? 0 : v_count+1) : v_count.
//  v_count <= v_next every cycle. The wrap from 524 to 0 occurs only on enable.
//  All decode uses (h=H_Count_Value, v=v_next). All outputs are registered: 1-cycle latency from h.
//  hsync is active for h in [656,751]. vsync is active for v in [490,491].
//  video_on = (h<640)&&(v<480). pixel_x = h[9:0], pixel_y = v[9:0] when video_on, else 0.
//  frame_start = (h==0)&&(v==0).
//  Out-of-range input: if h>=800, treat as blanking: video_on=0, hsync inactive, no v update beyond enable rule.
//  The horizontal counter has no reset. The partial line after rst_n release counts as line 0.
//   The first enable advances v_count to 1. Alignment is reached at the next 524->0 wrap.
//  Reset asserted mid-frame: outputs go to reset values immediately, regardless of clock.
//  No handshake; the block is free-running and cannot stall.
// CONFIGURATION
//  FRAME_COUNTER_EN defined: adds output frame_count [7:0].
//   frame_count resets to 0 and increments, wrapping 255->0, in the cycle frame_start is registered high.
//  FRAME_COUNTER_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package vga_timing_pkg holds the following:
//   - default H_/V_ parameter values and derived H_TOTAL, V_TOTAL.
//   - sync start/end localparams.
//   - the 10-bit coordinate width.
//  Sub-module vga_line_counter holds v_count/v_next with its wrap rule.
//  The top level holds decode and output registers.
// TESTING
//  Release rst_n, drive reference H count for 2 frames -> vsync low exactly 2 lines (1600 cycles) per frame.
//   Frame period is 420000 cycles.
//  h=655,656,751,752 at v=0 -> hsync one cycle later reads 1,0,0,1.
//  h=639 then 640 at v=479 -> video_on 1 then 0; pixel_x=639, pixel_y=479 on the last visible pixel.
//  v_count=524 with enable at h=0 -> v wraps to 0; frame_start pulses once, one cycle later.
//  Assert rst_n low at (h=300,v=200) for 3 cycles -> all outputs at reset values within the assert cycle.
//   After release, v resumes from 0.
//  FRAME_COUNTER_EN defined, run 257 frames -> frame_count wraps to 1.
//  Force h=900 -> video_on=0 and hsync inactive.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 Hz timing constants, coordinate type and output bundle.
// Ports: none (package). Used by vga_line_counter and vga_sync_generator.
// Latency/backpressure: n/a; the constants are consumed by free-running logic that never stalls.
`timescale 1ns/1ps
package vga_timing_pkg;

  // Horizontal timing, in pixel-clock cycles.
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines.
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  // Inclusive sync windows: the sync pulse follows the front porch directly.
  localparam int H_SYNC_START = H_VISIBLE + H_FP;               // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;      // 751
  localparam int V_SYNC_START = V_VISIBLE + V_FP;               // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;      // 491

  // Active level of hsync/vsync (0 = negative-going pulses).
  localparam logic SYNC_POL = 1'b0;

  // Width of pixel_x / pixel_y and of the line counter.
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Everything the output register stage holds, as one word.
  typedef struct packed {
    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   frame_start;
  } vga_out_t;

  // Output word driven while in reset: syncs idle at their inactive level.
  function automatic vga_out_t vga_out_idle(input logic sync_pol);
    vga_out_t o;
    o.hsync       = ~sync_pol;
    o.vsync       = ~sync_pol;
    o.video_on    = 1'b0;
    o.pixel_x     = '0;
    o.pixel_y     = '0;
    o.frame_start = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/vga_line_counter.sv
// vga_line_counter: vertical line counter 0..V_TOTAL-1, advanced by the horizontal line-wrap enable.
// Ports: clk_25Mhz, rst_n (async, active-low), enable_V_Counter in; v_count (registered), v_next (comb) out.
// Latency: v_next is combinational from enable; v_count follows one cycle later. Never stalls.
`timescale 1ns/1ps
module vga_line_counter
  import vga_timing_pkg::*;
#(
  parameter int V_TOTAL_P = V_TOTAL
) (
  input  logic   clk_25Mhz,
  input  logic   rst_n,
  input  logic   enable_V_Counter,
  output coord_t v_count,
  output coord_t v_next
);

  localparam coord_t V_LAST = coord_t'(V_TOTAL_P - 1);

  // Wrap back to line 0 only on an enable seen while on the last line;
  // without an enable the line holds, whatever the horizontal position.
  always_comb begin
    v_next = v_count;
    if (enable_V_Counter) begin
      if (v_count == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = v_count + coord_t'(1);
      end
    end
  end

  // The horizontal counter is not reset with us, so the partial line that
  // follows reset release is simply treated as line 0.
  always_ff @(posedge clk_25Mhz or negedge rst_n) begin
    if (!rst_n) begin
      v_count <= '0;
    end else begin
      v_count <= v_next;
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: decodes the horizontal count and the owned line count into registered
//   hsync/vsync, video_on, pixel_x/pixel_y and frame_start for the pixel/RGB stage.
// Ports: clk_25Mhz, rst_n, H_Count_Value[15:0], enable_V_Counter in; hsync, vsync, video_on,
//   pixel_x[9:0], pixel_y[9:0], frame_start out (+ frame_count[7:0] when FRAME_COUNTER_EN).
// Latency: 1 cycle from H_Count_Value to every output. Free-running, no handshake, cannot stall.
// Build option: define FRAME_COUNTER_EN to add the frame_count output.
`timescale 1ns/1ps
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE_P = H_VISIBLE,
  parameter int   H_FP_P      = H_FP,
  parameter int   H_SYNC_P    = H_SYNC,
  parameter int   H_BP_P      = H_BP,
  parameter int   V_VISIBLE_P = V_VISIBLE,
  parameter int   V_FP_P      = V_FP,
  parameter int   V_SYNC_P    = V_SYNC,
  parameter int   V_BP_P      = V_BP,
  parameter logic SYNC_POL_P  = SYNC_POL
) (
  input  logic        clk_25Mhz,
  input  logic        rst_n,
  input  logic [15:0] H_Count_Value,
  input  logic        enable_V_Counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output coord_t      pixel_x,
  output coord_t      pixel_y,
  output logic        frame_start
`ifdef FRAME_COUNTER_EN
  ,
  output logic [7:0]  frame_count
`endif
);

  // Derived timing, sized to the signals they are compared against.
  localparam int H_TOTAL_I = H_VISIBLE_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int V_TOTAL_I = V_VISIBLE_P + V_FP_P + V_SYNC_P + V_BP_P;

  localparam logic [15:0] H_TOTAL_W  = 16'(H_TOTAL_I);
  localparam logic [15:0] H_VIS_W    = 16'(H_VISIBLE_P);
  localparam logic [15:0] H_SS_W     = 16'(H_VISIBLE_P + H_FP_P);
  localparam logic [15:0] H_SE_W     = 16'(H_VISIBLE_P + H_FP_P + H_SYNC_P - 1);
  localparam coord_t      V_VIS_C    = coord_t'(V_VISIBLE_P);
  localparam coord_t      V_SS_C     = coord_t'(V_VISIBLE_P + V_FP_P);
  localparam coord_t      V_SE_C     = coord_t'(V_VISIBLE_P + V_FP_P + V_SYNC_P - 1);

  // ------------------------------------------------------------------
  // Vertical line counter
  // ------------------------------------------------------------------
  coord_t v_count;
  coord_t v_next;

  vga_line_counter #(
    .V_TOTAL_P (V_TOTAL_I)
  ) u_line_counter (
    .clk_25Mhz        (clk_25Mhz),
    .rst_n            (rst_n),
    .enable_V_Counter (enable_V_Counter),
    .v_count          (v_count),
    .v_next           (v_next)
  );

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  // Decoding against v_next (not v_count) lines the vertical outputs up with
  // the horizontal ones: the line change takes effect on the h==0 cycle that
  // carries the enable, so both land in the same registered output cycle.
  logic     h_in_range;
  logic     h_sync_act;
  logic     v_sync_act;
  logic     vis;
  vga_out_t out_d;
  vga_out_t out_q;

  always_comb begin
    // A count of H_TOTAL or more is a broken upstream counter: treat it as
    // blanking so nothing visible or sync-like leaks out.
    h_in_range = (H_Count_Value < H_TOTAL_W);
    h_sync_act = h_in_range && (H_Count_Value >= H_SS_W) && (H_Count_Value <= H_SE_W);
    v_sync_act = (v_next >= V_SS_C) && (v_next <= V_SE_C);
    vis        = h_in_range && (H_Count_Value < H_VIS_W) && (v_next < V_VIS_C);

    out_d             = vga_out_idle(SYNC_POL_P);
    out_d.hsync       = h_sync_act ? SYNC_POL_P : ~SYNC_POL_P;
    out_d.vsync       = v_sync_act ? SYNC_POL_P : ~SYNC_POL_P;
    out_d.video_on    = vis;
    out_d.pixel_x     = vis ? H_Count_Value[COORD_W-1:0] : '0;
    out_d.pixel_y     = vis ? v_next : '0;
    out_d.frame_start = (H_Count_Value == 16'd0) && (v_next == '0);
  end

  // ------------------------------------------------------------------
  // Output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_25Mhz or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= vga_out_idle(SYNC_POL_P);
    end else begin
      out_q <= out_d;
    end
  end

  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign pixel_x     = out_q.pixel_x;
  assign pixel_y     = out_q.pixel_y;
  assign frame_start = out_q.frame_start;

`ifdef FRAME_COUNTER_EN
  // ------------------------------------------------------------------
  // Frame counter: steps on the same edge that registers frame_start high,
  // so frame_count and the frame_start pulse become visible together.
  // ------------------------------------------------------------------
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk_25Mhz or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (out_d.frame_start) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
`timescale 1ns/1ps
module tb_vga_sync_generator;

  logic        clk_25Mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic [15:0] H_Count_Value = 16'd0;
  logic        enable_V_Counter = 1'b0;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
`ifdef FRAME_COUNTER_EN
  logic [7:0]  frame_count;
`endif

  int total = 0;
  int bad   = 0;
  int cur_v = 0;   // expected line the DUT is on, stepped by the documented wrap rule

  always #20 clk_25Mhz = ~clk_25Mhz;

  vga_sync_generator dut (
    .clk_25Mhz        (clk_25Mhz),
    .rst_n            (rst_n),
    .H_Count_Value    (H_Count_Value),
    .enable_V_Counter (enable_V_Counter),
    .hsync            (hsync),
    .vsync            (vsync),
    .video_on         (video_on),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .frame_start      (frame_start)
`ifdef FRAME_COUNTER_EN
    ,
    .frame_count      (frame_count)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one input cycle; on return the registered outputs reflect it.
  task automatic cyc(input int h, input logic en);
    H_Count_Value    = 16'(h);
    enable_V_Counter = en;
    @(posedge clk_25Mhz);
    #1;
  endtask

  // Compressed lines (enable at h=0, then one blanking cycle) up to a target line.
  task automatic goto_line(input int target);
    while (cur_v != target) begin
      cyc(0, 1'b1);
      cur_v = (cur_v == 524) ? 0 : cur_v + 1;
      cyc(700, 1'b0);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_hsync"},  32'(hsync),       32'd1);
    check_val({tag, "_vsync"},  32'(vsync),       32'd1);
    check_val({tag, "_video"},  32'(video_on),    32'd0);
    check_val({tag, "_px"},     32'(pixel_x),     32'd0);
    check_val({tag, "_py"},     32'(pixel_y),     32'd0);
    check_val({tag, "_fs"},     32'(frame_start), 32'd0);
  endtask

  initial begin
    int hs_cnt;
    int vid_cnt;
    int vs_cnt;
    int fs_cnt;
    int cnt;
    int fs_at[2];

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    cyc(0, 1'b0);
    cyc(0, 1'b0);
    check_idle("reset");
`ifdef FRAME_COUNTER_EN
    check_val("reset_fcnt", 32'(frame_count), 32'd0);
`endif
    rst_n = 1'b1;
    cur_v = 0;

    // ---------------- hsync edges at v=0 ----------------
    cyc(655, 1'b0); check_val("hs_655", 32'(hsync), 32'd1);
    cyc(656, 1'b0); check_val("hs_656", 32'(hsync), 32'd0);
    cyc(751, 1'b0); check_val("hs_751", 32'(hsync), 32'd0);
    cyc(752, 1'b0); check_val("hs_752", 32'(hsync), 32'd1);
    check_val("v0_vsync", 32'(vsync), 32'd1);
    cyc(5, 1'b0);
    check_val("v0_video", 32'(video_on), 32'd1);
    check_val("v0_px",    32'(pixel_x),  32'd5);
    check_val("v0_py",    32'(pixel_y),  32'd0);

    // ---------------- one full reference line (becomes line 1) ----------------
    hs_cnt = 0; vid_cnt = 0; fs_cnt = 0;
    for (int h = 0; h < 800; h++) begin
      cyc(h, h == 0);
      if (hsync == 1'b0) hs_cnt++;
      if (video_on) vid_cnt++;
      if (frame_start) fs_cnt++;
      if (h == 0) check_val("line1_py", 32'(pixel_y), 32'd1);
    end
    cur_v = 1;
    check_val("line_hsync_cycles", 32'(hs_cnt),  32'd96);
    check_val("line_video_cycles", 32'(vid_cnt), 32'd640);
    check_val("line_no_fs",        32'(fs_cnt),  32'd0);

    // ---------------- last visible pixel ----------------
    goto_line(479);
    cyc(639, 1'b0);
    check_val("v479_h639_video", 32'(video_on), 32'd1);
    check_val("v479_h639_px",    32'(pixel_x),  32'd639);
    check_val("v479_h639_py",    32'(pixel_y),  32'd479);
    cyc(640, 1'b0);
    check_val("v479_h640_video", 32'(video_on), 32'd0);
    check_val("v479_h640_px",    32'(pixel_x),  32'd0);
    goto_line(480);
    cyc(0, 1'b0);
    check_val("v480_video", 32'(video_on), 32'd0);
    check_val("v480_py",    32'(pixel_y),  32'd0);

    // ---------------- vsync boundaries ----------------
    goto_line(489); cyc(10, 1'b0); check_val("vs_489", 32'(vsync), 32'd1);
    goto_line(490); cyc(10, 1'b0); check_val("vs_490", 32'(vsync), 32'd0);
    goto_line(491); cyc(10, 1'b0); check_val("vs_491", 32'(vsync), 32'd0);
    goto_line(492); cyc(10, 1'b0); check_val("vs_492", 32'(vsync), 32'd1);

    // ---------------- two compressed frames (2 cycles per line) ----------------
    goto_line(524);
    cnt = 0;
    fs_at[0] = -1;
    fs_at[1] = -1;
    for (int f = 0; f < 2; f++) begin
      vs_cnt = 0; fs_cnt = 0;
      for (int l = 0; l < 525; l++) begin
        cyc(0, 1'b1);
        cur_v = (cur_v == 524) ? 0 : cur_v + 1;
        if (vsync == 1'b0) vs_cnt++;
        if (frame_start) begin fs_cnt++; fs_at[f] = cnt; end
        cnt++;
        cyc(700, 1'b0);
        if (vsync == 1'b0) vs_cnt++;
        if (frame_start) fs_cnt++;
        cnt++;
      end
      check_val("frame_vsync_cycles", 32'(vs_cnt), 32'd4);
      check_val("frame_fs_pulses",    32'(fs_cnt), 32'd1);
    end
    check_val("frame_period", 32'(fs_at[1] - fs_at[0]), 32'd1050);

    // ---------------- wrap 524 -> 0 ----------------
    check_val("pre_wrap_line", 32'(cur_v), 32'd524);
    cyc(0, 1'b1);
    cur_v = 0;
    check_val("wrap_fs",    32'(frame_start), 32'd1);
    check_val("wrap_video", 32'(video_on),    32'd1);
    check_val("wrap_py",    32'(pixel_y),     32'd0);
    cyc(1, 1'b0);
    check_val("wrap_fs_once", 32'(frame_start), 32'd0);
    check_val("wrap_px1",     32'(pixel_x),     32'd1);

    // ---------------- out-of-range h ----------------
    cyc(900, 1'b0);
    check_val("h900_video", 32'(video_on), 32'd0);
    check_val("h900_hsync", 32'(hsync),    32'd1);
    check_val("h900_px",    32'(pixel_x),  32'd0);

    // ---------------- asynchronous reset mid-frame ----------------
    goto_line(200);
    cyc(300, 1'b0);
    check_val("mid_video", 32'(video_on), 32'd1);
    check_val("mid_px",    32'(pixel_x),  32'd300);
    check_val("mid_py",    32'(pixel_y),  32'd200);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    cyc(301, 1'b0);
    cyc(302, 1'b0);
    cyc(303, 1'b0);
    check_idle("held_rst");
    rst_n = 1'b1;
    cur_v = 0;
    cyc(10, 1'b0);
    check_val("resume_video", 32'(video_on), 32'd1);
    check_val("resume_py0",   32'(pixel_y),  32'd0);
    cyc(0, 1'b1);
    cur_v = 1;
    check_val("resume_py1",   32'(pixel_y),  32'd1);

`ifdef FRAME_COUNTER_EN
    // ---------------- frame counter wrap ----------------
    // Holding line 0 without enables, every h=0 cycle decodes position (0,0).
    rst_n = 1'b0;
    cyc(0, 1'b0);
    rst_n = 1'b1;
    cur_v = 0;
    check_val("fcnt_reset", 32'(frame_count), 32'd0);
    for (int i = 0; i < 257; i++) begin
      cyc(0, 1'b0);
      if (i == 0) begin
        check_val("fcnt_first",    32'(frame_count), 32'd1);
        check_val("fcnt_first_fs", 32'(frame_start), 32'd1);
      end
      cyc(1, 1'b0);
    end
    check_val("fcnt_wrap", 32'(frame_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
